// File: rtl/opentry_pkg.sv
`default_nettype none
// ============================================================================
// Module   : opentry_pkg
// Purpose  : Shared types and widths for the operand entry front panel.
// Revision : 1.0 - initial release
// ============================================================================
package opentry_pkg;

    localparam int A_W              = 7;
    localparam int B_W              = 7;
    localparam int OP_W             = 2;
    localparam int DEBOUNCE_DEFAULT = 500000;

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        LOAD_OP = 2'd2,
        DONE    = 2'd3
    } stage_t;

    // Step-back target; LOAD_A has no predecessor and stays put.
    function automatic stage_t prev_stage(input stage_t s);
        stage_t r;
        case (s)
            LOAD_B:  r = LOAD_A;
            LOAD_OP: r = LOAD_B;
            DONE:    r = LOAD_OP;
            default: r = LOAD_A;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Purpose  : Raw button -> 2-flop sync -> debouncer -> registered press pulse.
//            Debouncer present only when OPENTRY_DEBOUNCE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce
    import opentry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_press
);

`ifdef OPENTRY_DEBOUNCE_EN
    localparam bit c_DEBOUNCE_EN = 1'b1;
`else
    localparam bit c_DEBOUNCE_EN = 1'b0;
`endif

    logic [1:0] r_sync;
    logic       w_level;
    logic       r_prev;
    logic       r_press;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[0], i_btn};
        end
    end

    generate
        if (c_DEBOUNCE_EN && (DEBOUNCE_CYCLES > 0)) begin : g_debounce
            localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
            localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

            logic               r_level;
            logic [c_CNT_W-1:0] r_cnt;

            // Any sample agreeing with the current level restarts the stability run.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_level <= 1'b0;
                    r_cnt   <= '0;
                end else if (r_sync[1] == r_level) begin
                    r_cnt   <= '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    r_level <= ~r_level;
                    r_cnt   <= '0;
                end else begin
                    r_cnt   <= r_cnt + c_CNT_W'(1);
                end
            end

            assign w_level = r_level;
        end else begin : g_bypass
            assign w_level = r_sync[1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev  <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_prev  <= w_level;
            r_press <= w_level & ~r_prev;
        end
    end

    assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/operand_entry.sv
`default_nettype none
// ============================================================================
// Module   : operand_entry
// Purpose  : Two-button operand/opcode entry FSM for a switch-bank ALU demo.
//            Define OPENTRY_DEBOUNCE_EN to enable per-button debouncing.
// Revision : 1.0 - initial release
// ============================================================================
module operand_entry
    import opentry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int SW_W            = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [SW_W-1:0] sw_in,
    input  logic            btn_next,
    input  logic            btn_back,
    output logic [A_W-1:0]  a_out,
    output logic [B_W-1:0]  b_out,
    output logic [OP_W-1:0] op_out,
    output logic [1:0]      stage,
    output logic            valid
);

    logic            w_next;
    logic            w_back;
    logic            w_ld_a;
    logic            w_ld_b;
    logic            w_ld_op;
    stage_t          r_stage;
    stage_t          w_stage_nxt;
    logic [A_W-1:0]  r_a;
    logic [B_W-1:0]  r_b;
    logic [OP_W-1:0] r_op;
    logic            r_valid;
    logic            w_unused_sw;

    assign w_unused_sw = ^sw_in[SW_W-1:A_W];

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db_next (
        .clk     (clk),
        .rst     (reset),
        .i_btn   (btn_next),
        .o_press (w_next)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db_back (
        .clk     (clk),
        .rst     (reset),
        .i_btn   (btn_back),
        .o_press (w_back)
    );

    // Coincident next/back pulses cancel each other out.
    always_comb begin
        w_stage_nxt = r_stage;
        w_ld_a      = 1'b0;
        w_ld_b      = 1'b0;
        w_ld_op     = 1'b0;
        if (w_next && !w_back) begin
            case (r_stage)
                LOAD_A: begin
                    w_ld_a      = 1'b1;
                    w_stage_nxt = LOAD_B;
                end
                LOAD_B: begin
                    w_ld_b      = 1'b1;
                    w_stage_nxt = LOAD_OP;
                end
                LOAD_OP: begin
                    w_ld_op     = 1'b1;
                    w_stage_nxt = DONE;
                end
                default: w_stage_nxt = LOAD_A;
            endcase
        end else if (w_back && !w_next) begin
            w_stage_nxt = prev_stage(r_stage);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stage <= LOAD_A;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_valid <= 1'b0;
        end else begin
            r_stage <= w_stage_nxt;
            if (w_ld_a)  r_a  <= sw_in[A_W-1:0];
            if (w_ld_b)  r_b  <= sw_in[B_W-1:0];
            if (w_ld_op) r_op <= sw_in[OP_W-1:0];
            r_valid <= w_ld_op;
        end
    end

    assign a_out  = r_a;
    assign b_out  = r_b;
    assign op_out = r_op;
    assign stage  = r_stage;
    assign valid  = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_operand_entry.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_entry
// Purpose  : Self-checking bench for operand_entry (DEBOUNCE_CYCLES = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_operand_entry;

    localparam int N = 4;
`ifdef OPENTRY_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
`else
    localparam bit DEB = 1'b0;
`endif
    localparam int LAT         = DEB ? N + 3 : 3;
    localparam int BOUNCE_INCR = DEB ? 1 : 3;
    localparam int HOLD        = N + 6;
    localparam int SETTLE      = N + 8;

    logic        clk;
    logic        reset;
    logic [15:0] sw_in;
    logic        btn_next;
    logic        btn_back;
    logic [6:0]  a_out;
    logic [6:0]  b_out;
    logic [1:0]  op_out;
    logic [1:0]  stage;
    logic        valid;

    operand_entry #(
        .DEBOUNCE_CYCLES (N),
        .SW_W            (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sw_in    (sw_in),
        .btn_next (btn_next),
        .btn_back (btn_back),
        .a_out    (a_out),
        .b_out    (b_out),
        .op_out   (op_out),
        .stage    (stage),
        .valid    (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;
    int valid_seen = 0;

    // Reference model: raw samples since reset, and the debounced level after each edge.
    bit rn[$];
    bit rb[$];
    bit ln[$];
    bit lb[$];
    int m_a, m_b, m_op, m_stage;
    bit m_valid;
    bit m_started = 1'b0;

    // Debounced level after edge k (k = l.size()); r holds raw samples 0..k.
    function automatic bit model_level(input bit r[$], input bit l[$]);
        int k;
        bit prev;
        k = l.size();
        prev = (k > 0) ? l[k-1] : 1'b0;
        if (!DEB) return (k >= 1) ? r[k-1] : 1'b0;
        if (k - 1 - N < 0) return prev;
        for (int j = k - 1 - N; j <= k - 2; j++)
            if (r[j] == prev) return prev;
        return ~prev;
    endfunction

    // Press acts at edge k when the level rose between edges k-3 and k-2.
    function automatic bit model_press(input bit l[$]);
        int k;
        bit l2, l3;
        k  = l.size();
        l2 = (k >= 2) ? l[k-2] : 1'b0;
        l3 = (k >= 3) ? l[k-3] : 1'b0;
        return l2 & ~l3;
    endfunction

    always @(posedge clk) begin
        bit pn, pb;
        m_started = 1'b1;
        if (reset) begin
            rn.delete(); rb.delete(); ln.delete(); lb.delete();
            m_a = 0; m_b = 0; m_op = 0; m_stage = 0; m_valid = 1'b0;
        end else begin
            pn = model_press(ln);
            pb = model_press(lb);
            rn.push_back(btn_next);
            rb.push_back(btn_back);
            ln.push_back(model_level(rn, ln));
            lb.push_back(model_level(rb, lb));
            m_valid = 1'b0;
            if (pn && !pb) begin
                case (m_stage)
                    0: begin m_a  = int'(sw_in[6:0]); m_stage = 1; end
                    1: begin m_b  = int'(sw_in[6:0]); m_stage = 2; end
                    2: begin m_op = int'(sw_in[1:0]); m_stage = 3; m_valid = 1'b1; end
                    default: m_stage = 0;
                endcase
            end else if (pb && !pn && m_stage > 0) begin
                m_stage = m_stage - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            n_vec++;
            if (valid === 1'b1) valid_seen++;
            if (a_out !== 7'(m_a) || b_out !== 7'(m_b) || op_out !== 2'(m_op) ||
                stage !== 2'(m_stage) || valid !== m_valid) begin
                n_fail++;
                $display("FAIL model t=%0t got a=%h b=%h op=%h stage=%0d valid=%b required a=%h b=%h op=%h stage=%0d valid=%b",
                         $time, a_out, b_out, op_out, stage, valid,
                         7'(m_a), 7'(m_b), 2'(m_op), m_stage, m_valid);
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic press(input bit n, input bit b, input logic [15:0] sw);
        sw_in    = sw;
        btn_next = n;
        btn_back = b;
        repeat (HOLD) @(negedge clk);
        btn_next = 1'b0;
        btn_back = 1'b0;
        repeat (SETTLE) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int v0;
        reset    = 1'b1;
        btn_next = 1'b0;
        btn_back = 1'b0;
        sw_in    = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_a", a_out, 0);
        check("rst_b", b_out, 0);
        check("rst_op", op_out, 0);
        check("rst_stage", stage, 0);
        check("rst_valid", valid, 0);

        // Full entry; upper switch bits must be ignored.
        press(1, 0, 16'h80B5);
        check("load_a", a_out, 'h35);
        check("stage_b", stage, 1);
        press(1, 0, 16'h008A);
        check("load_b", b_out, 'h0A);
        check("stage_op", stage, 2);
        v0       = valid_seen;
        sw_in    = 16'hFFF6;
        btn_next = 1'b1;
        repeat (LAT) @(negedge clk);
        check("pre_lat_stage", stage, 2);
        check("pre_lat_valid", valid, 0);
        @(negedge clk);
        check("lat_stage", stage, 3);
        check("lat_valid", valid, 1);
        @(negedge clk);
        check("valid_one_cycle", valid, 0);
        btn_next = 1'b0;
        repeat (SETTLE) @(negedge clk);
        check("done_a", a_out, 'h35);
        check("done_b", b_out, 'h0A);
        check("done_op", op_out, 2);
        check("valid_count", valid_seen - v0, 1);

        // Bouncing next button from DONE.
        sw_in = 16'h0044;
        for (int i = 0; i < 2; i++) begin
            btn_next = 1'b1;
            repeat (2) @(negedge clk);
            btn_next = 1'b0;
            repeat (2) @(negedge clk);
        end
        btn_next = 1'b1;
        repeat (HOLD) @(negedge clk);
        btn_next = 1'b0;
        repeat (SETTLE) @(negedge clk);
        check("bounce_stage", stage, (3 + BOUNCE_INCR) % 4);

        // Back from LOAD_OP, then re-enter B.
        do_reset();
        press(1, 0, 16'h0035);
        press(1, 0, 16'h000A);
        v0 = valid_seen;
        press(0, 1, 16'h0055);
        check("back_stage", stage, 1);
        check("back_b_kept", b_out, 'h0A);
        press(1, 0, 16'h0011);
        check("reload_b", b_out, 'h11);
        check("reload_a_kept", a_out, 'h35);
        check("reload_stage", stage, 2);
        check("back_no_valid", valid_seen - v0, 0);

        // Simultaneous next+back in LOAD_B.
        press(0, 1, 16'h0000);
        press(1, 1, 16'h007F);
        check("both_stage", stage, 1);
        check("both_a", a_out, 'h35);
        check("both_b", b_out, 'h11);

        // DONE->back->LOAD_OP, then wrap to LOAD_A holding registers.
        press(1, 0, 16'h0022);
        press(1, 0, 16'h0001);
        check("op1", op_out, 1);
        press(0, 1, 16'h0000);
        check("done_back_stage", stage, 2);
        check("done_back_op", op_out, 1);
        press(1, 0, 16'h0003);
        check("op3", op_out, 3);
        press(1, 0, 16'h007F);
        check("wrap_stage", stage, 0);
        check("wrap_a", a_out, 'h35);
        check("wrap_b", b_out, 'h22);
        check("wrap_op", op_out, 3);
        press(0, 1, 16'h0000);
        check("back_in_a", stage, 0);

        // Reset in LOAD_OP with next held through release.
        press(1, 0, 16'h0010);
        press(1, 0, 16'h0020);
        check("pre_rst_stage", stage, 2);
        btn_next = 1'b1;
        reset    = 1'b1;
        sw_in    = 16'h005A;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (LAT) @(negedge clk);
        check("held_rst_stage", stage, 0);
        check("held_rst_a", a_out, 0);
        @(negedge clk);
        check("held_adv_stage", stage, 1);
        check("held_adv_a", a_out, 'h5A);
        btn_next = 1'b0;
        repeat (SETTLE) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/operand_entry.md
OPERAND_ENTRY -- requirements
Module: operand_entry

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, is the number of consecutive stable clk cycles required before a debounced button changes level (5 ms at 100 MHz).
REQ-002 Parameter SW_W, default 16, is the width of the switch bank.
REQ-003 clk  input  1  system clock, 100 MHz; all logic is on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 sw_in  input  SW_W  raw slide-switch bank; only bits [6:0] are used.
REQ-006 btn_next  input  1  raw, asynchronous, bouncing "advance" pushbutton.
REQ-007 btn_back  input  1  raw, asynchronous, bouncing "step back" pushbutton.
REQ-008 a_out  output  7  latched operand A.
REQ-009 b_out  output  7  latched operand B.
REQ-010 op_out  output  2  latched ALU opcode.
REQ-011 stage  output  2  current FSM state encoding, intended for LEDs.
REQ-012 valid  output  1  single-cycle pulse when a complete operand set has been captured.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer, then a debouncer, then a rising-edge detector that yields a 1-cycle press pulse.
REQ-014 Debouncer: the counter SHALL reset to 0 whenever the synchronized input equals the debounced level; the level SHALL toggle when the counter reaches DEBOUNCE_CYCLES-1.
REQ-015 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL produce no press pulse.
REQ-016 Latency from the first cycle a clean high is sampled on a raw button to the stage/register update SHALL be exactly DEBOUNCE_CYCLES+3 cycles; a bench checks this value.
REQ-017 FSM states and encodings: LOAD_A=0, LOAD_B=1, LOAD_OP=2, DONE=3.
REQ-018 Next press in LOAD_A: a_out <= sw_in[6:0], go to LOAD_B.
REQ-019 Next press in LOAD_B: b_out <= sw_in[6:0], go to LOAD_OP.
REQ-020 Next press in LOAD_OP: op_out <= sw_in[1:0], go to DONE, and valid=1 in the following cycle only.
REQ-021 Next press in DONE: go to LOAD_A; registers SHALL hold their values until overwritten.
REQ-022 Back press SHALL move to the previous state: LOAD_B->LOAD_A, LOAD_OP->LOAD_B, DONE->LOAD_OP; in LOAD_A it SHALL have no effect. Back SHALL NOT modify any register or pulse valid.
REQ-023 Next and back press pulses in the same cycle SHALL both be ignored.
REQ-024 A held button SHALL produce exactly one press pulse per press.
REQ-025 valid SHALL never be high for two consecutive cycles.

Reset
REQ-026 While reset=1 on a clock edge, the block SHALL set stage=LOAD_A, a_out=0, b_out=0, op_out=0, valid=0, synchronizer flops=0, debounced levels=0 and counters=0.
REQ-027 Reset mid-entry or mid-debounce SHALL discard the partial entry.
REQ-028 A button held through reset release SHALL generate a press pulse only after a full DEBOUNCE_CYCLES stable period.

Configuration
REQ-029 With OPENTRY_DEBOUNCE_EN defined, the debouncer of REQ-014 SHALL be instantiated on each button.
REQ-030 Without OPENTRY_DEBOUNCE_EN, the synchronizer output SHALL feed the edge detector directly, and the REQ-016 latency SHALL become 3 cycles; this mode is for simulation speed.

Structure
REQ-031 Package opentry_pkg SHALL hold the state enum (stage_t), the width constants A_W=7, B_W=7, OP_W=2, and the default debounce count.
REQ-032 Sub-module btn_debounce SHALL contain the synchronizer, debouncer and edge detector, SHALL be parameterized by DEBOUNCE_CYCLES, and SHALL be instantiated once per button.

Verification
REQ-033 DEBOUNCE_CYCLES=4, macro defined. Assert reset, then release -> all outputs 0 and stage=0.
REQ-034 sw_in[6:0]=0x35 then next, 0x0A then next, 0x2 then next -> a_out=0x35, b_out=0x0A, op_out=2, stage=3, and valid high exactly 1 cycle, 7 cycles after the final press.
REQ-035 btn_next bouncing 1-0-1-0 at 2-cycle intervals, then stable high -> exactly one stage increment.
REQ-036 In LOAD_OP press back, then next with sw=0x11 -> b_out=0x11, a_out unchanged, and no valid pulse.
REQ-037 Next and back pressed in the same cycle in LOAD_B -> stage stays 1 and registers are unchanged.
REQ-038 Reset asserted in LOAD_OP with btn_next held high -> stage=0, and no advance until 7 cycles after reset release.
